bus_initiator: RTL
==================

# bus_initiator

Single-outstanding bus master that drives the `protocol` side of `bus_protocol_if`. It issues one read or write per command toward a peripheral such as `AHBuart`, and holds the transaction across `request_stall` wait states. It returns read data and error status on a response handshake. It replaces hand-driven `wen`/`addr`/`wdata` stimulus in benches and serves as the bridge from simple command sources (CPU shim, debug FSM) onto the peripheral bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, bus address width; must match the interface.
- `DATA_WIDTH`, 32, bus data width; multiple of 8.
- `TIMEOUT_CYCLES`, 255, maximum stalled cycles before abort. Used only with the timeout feature; range 1..65535.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  command accepted when high together with `req_valid` at an edge.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  offset address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_strobe`  in  DATA_WIDTH/8  byte enables for writes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when high with `rsp_valid` at an edge.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes.
- `rsp_error`  out  1  peripheral `error`, or timeout abort.
- `rsp_timeout`  out  1  abort due to stall timeout.
- `busy`  out  1  state is not IDLE.
- `bp`  interface  —  `bus_protocol_if.protocol`. Drives `wen`, `ren`, `addr`, `wdata` and `strobe`; hint signals are tied to 0. Samples `rdata`, `error` and `request_stall`.

## Operation
- There are three states: IDLE, ACCESS and RESP.
- **IDLE**
  - `req_ready`=1.
  - On accept, latch write/addr/wdata/strobe and go to ACCESS.
- **ACCESS**
  - Drives `wen`=write, `ren`=!write, `addr` and `wdata`.
  - `strobe` = latched strobe for writes, all-zero for reads.
  - All bus outputs are registered and stable for the whole of ACCESS.
- **Completion**
  - Completion is the first edge in ACCESS with `request_stall`=0.
  - At that edge, capture `rdata` (reads only; writes load 0) and `error`.
  - At that same edge, drop `wen`/`ren` and go to RESP.
- **RESP**
  - `rsp_valid`=1 with stable response fields until `rsp_ready`, then return to IDLE.
  - `req_ready`=0 in ACCESS and RESP; there is no back-to-back overlap.
- Response fields are cleared on entering ACCESS.
- `wen` and `ren` are never high together.
- Outside ACCESS, `wen`=`ren`=0 and `addr`/`wdata`/`strobe` hold their last value.

## Timing
- **Reset values**
  - State IDLE.
  - `req_ready`=1, `busy`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `rsp_timeout`=0.
  - `bp.wen`=`bp.ren`=0, `bp.addr`=0, `bp.wdata`=0, `bp.strobe`=0.
- **Latency**
  - Accept at edge k; `wen`/`ren` high from cycle k+1.
  - With S stalled cycles, completion occurs at edge k+1+S.
  - `rsp_valid` is high from cycle k+2+S.
  - The minimum command-to-command period is 3 cycles, with `rsp_ready` held high.
- `req_valid` while busy is ignored and not latched.
- `rsp_ready` high while `rsp_valid`=0 has no effect.
- `request_stall` outside ACCESS is ignored.
- `error` is sampled only on the completion edge; `error` during stalled cycles is ignored.
- Asynchronous reset mid-ACCESS or mid-RESP:
  - Bus strobes drop immediately.
  - The command is discarded and no response is produced.

## Configuration
- Macro `BUS_INITIATOR_TIMEOUT_EN`.
- **Defined**
  - A 16-bit stall counter clears on entering ACCESS and increments on each ACCESS cycle with `request_stall`=1.
  - When the counter equals `TIMEOUT_CYCLES` and stall is still high, abort at that edge: drop `wen`/`ren`, set `rsp_error`=1, `rsp_timeout`=1, `rsp_rdata`=0, and go to RESP.
  - If stall deasserts on the same edge as the counter match, normal completion wins.
- **Undefined**
  - No counter; ACCESS waits indefinitely.
  - `rsp_timeout` is tied to 0.

## Test plan
- **Write, no stall:** reset, then write addr=24, wdata=0x0F, strobe=4'h1, stall=0.
  - `wen`=1 for exactly 1 cycle with addr=24, wdata=0x0F.
  - `rsp_valid` 2 cycles after accept, `rsp_error`=0, `rsp_rdata`=0.
- **Read, 3 stalls:** read addr=0x10; peripheral stalls 3 cycles, then returns rdata=0xA5.
  - `ren` high for 4 cycles with addr stable.
  - `rsp_rdata`=0xA5, `rsp_error`=0.
- **Error plus backpressure:** write; `error`=1 on completion cycle; `rsp_ready` held low for 5 cycles.
  - `rsp_valid`/`rsp_error`=1 held for 5 cycles.
  - `req_ready`=0 throughout.
  - A second `req_valid` is not accepted until after the response handshake.
- **Timeout:** build with `BUS_INITIATOR_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4; stall stuck high.
  - `ren` drops after 4 stalled cycles.
  - `rsp_error`=1, `rsp_timeout`=1.
  - Without the macro, `ren` remains high for 100 cycles.
- **Reset mid-transaction:** assert `nReset`=0 two cycles into a stalled write.
  - `wen` falls without waiting for a clock edge.
  - After release: IDLE, `req_ready`=1, `rsp_valid` never asserted.
- **Back-to-back:** write 0x11 to addr 0, then read addr 0 with `rsp_ready`=1 and stall=0.
  - Accepts are 3 cycles apart.
  - `wen` and `ren` are never simultaneously high.

Source files
------------

// File: rtl/bus_initiator_if.sv
// Peripheral-side bus bundle shared by a bus master and one peripheral.
// Combinational wiring only; no latency of its own.
// Backpressure is the peripheral's request_stall, honoured by the master.
interface bus_protocol_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    wen;
  logic                    ren;
  logic                    request_stall;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    error;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  // Burst/security hints; this master only ever issues single plain transfers.
  logic                    is_burst;
  logic [1:0]              burst_type;
  logic [7:0]              burst_length;
  logic                    secure_transfer;

  modport peripheral_vital (
    input  wen, ren, addr, wdata, strobe,
           is_burst, burst_type, burst_length, secure_transfer,
    output rdata, error, request_stall
  );

  modport protocol (
    input  rdata, error, request_stall,
    output wen, ren, addr, wdata, strobe,
           is_burst, burst_type, burst_length, secure_transfer
  );
endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding bus master: one command in, one bus access, one response out.
// Latency: strobes from cycle after accept; response 2+S cycles after accept (S = stalls).
// Backpressure: request_stall holds the access; rsp_ready low holds the response.
// Optional stall timeout enabled by defining BUS_INITIATOR_TIMEOUT_EN.
module bus_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strobe,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    busy,
  bus_protocol_if.protocol        bp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    wen_q;
  logic                    ren_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strobe_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    error_q;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic        timeout_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Next stall count while the peripheral keeps stalling.
  always_comb begin
    stall_cnt_d = stall_cnt_q + 16'd1;
  end
`endif

  // Whole transaction FSM; every bus and response output is a register here.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strobe_q    <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // Command is loaded straight into the bus registers so the
            // strobes appear the cycle after accept and stay stable.
            state_q  <= ACCESS;
            wen_q    <= req_write;
            ren_q    <= !req_write;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            strobe_q <= req_write ? req_strobe : '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
`endif
          end
        end
        ACCESS: begin
          if (!bp.request_stall) begin
            // Completion: error is only meaningful on this edge.
            state_q <= RESP;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            rdata_q <= wen_q ? '0 : bp.rdata;
            error_q <= bp.error;
          end
`ifdef BUS_INITIATOR_TIMEOUT_EN
          else if (stall_cnt_q == TIMEOUT_LIMIT) begin
            state_q   <= RESP;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            stall_cnt_q <= stall_cnt_d;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign bp.wen             = wen_q;
  assign bp.ren             = ren_q;
  assign bp.addr            = addr_q;
  assign bp.wdata           = wdata_q;
  assign bp.strobe          = strobe_q;
  assign bp.is_burst        = 1'b0;
  assign bp.burst_type      = 2'b00;
  assign bp.burst_length    = 8'd0;
  assign bp.secure_transfer = 1'b0;

endmodule
